// File: rtl/uart_responder.sv
// uart_responder: 8N1 UART peripheral behind an rdn/wrn bus; define UART_RX_FIFO_EN to replace the single RBR with an RX FIFO
module uart_responder #(
  parameter int CLK_DIV       = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       tx_overrun
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  if (CLK_DIV < 4 || RX_FIFO_DEPTH < 2) begin : g_bad_param
    $error("uart_responder: CLK_DIV must be >= 4 and RX_FIFO_DEPTH >= 2");
  end
  state_t        tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    thr_q, thr_d, tsr_q, tsr_d, rx_sh_q, rx_sh_d;
  logic          tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
  logic          wrn_q, rdn_q, rx_s1_q, rx_s2_q;
  logic          dr_q, dr_d, ferr_q, ferr_d, rxo_q, rxo_d, txo_q, txo_d;
  logic          wr_edge, rd_edge, pop, push, rxo_set, ferr_set;
  assign wr_edge    = ~wrn_q & wrn;
  assign rd_edge    = ~rdn_q & rdn;
  assign pop        = rd_edge & dr_q;
  assign bus_oe     = ~rdn;
  assign data_ready = dr_q;
  assign tbre       = tbre_q;
  assign tsre       = tsre_q;
  assign txd        = txd_q;
  assign frame_err  = ferr_q;
  assign rx_overrun = rxo_q;
  assign tx_overrun = txo_q;
  // State registers; reset abandons any frame and drives the line idle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q  <= IDLE;
      rx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      thr_q    <= '0;
      tsr_q    <= '0;
      rx_sh_q  <= '0;
      tbre_q   <= 1'b1;
      tsre_q   <= 1'b1;
      txd_q    <= 1'b1;
      wrn_q    <= 1'b1;
      rdn_q    <= 1'b1;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      dr_q     <= 1'b0;
      ferr_q   <= 1'b0;
      rxo_q    <= 1'b0;
      txo_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      rx_st_q  <= rx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      thr_q    <= thr_d;
      tsr_q    <= tsr_d;
      rx_sh_q  <= rx_sh_d;
      tbre_q   <= tbre_d;
      tsre_q   <= tsre_d;
      txd_q    <= txd_d;
      wrn_q    <= wrn;
      rdn_q    <= rdn;
      rx_s1_q  <= rxd;
      rx_s2_q  <= rx_s1_q;
      dr_q     <= dr_d;
      ferr_q   <= ferr_d;
      rxo_q    <= rxo_d;
      txo_q    <= txo_d;
    end
  end
  // Holding register write and transmit FSM; a load needs tbre=0 and a write needs tbre=1, so they never collide
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    thr_d    = thr_q;
    tsr_d    = tsr_q;
    tbre_d   = tbre_q;
    tsre_d   = tsre_q;
    txd_d    = txd_q;
    if (wr_edge && tbre_q) begin
      thr_d  = bus_din;
      tbre_d = 1'b0;
    end
    case (tx_st_q)
      IDLE: if (!tbre_q) begin
        tsr_d    = thr_q;
        tbre_d   = 1'b1;
        tsre_d   = 1'b0;
        txd_d    = 1'b0;
        tx_cnt_d = '0;
        tx_st_d  = START;
      end
      START: if (tx_cnt_q == BIT_END) begin
        txd_d    = tsr_q[0];
        tsr_d    = {1'b0, tsr_q[7:1]};
        tx_bit_d = '0;
        tx_st_d  = DATA;
      end
      DATA: if (tx_cnt_q == BIT_END) begin
        txd_d    = (tx_bit_q == 3'd7) ? 1'b1 : tsr_q[0];
        tsr_d    = {1'b0, tsr_q[7:1]};
        tx_bit_d = tx_bit_q + 1'b1;
        tx_st_d  = (tx_bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (tx_cnt_q == BIT_END) begin
        tsre_d  = 1'b1;
        tx_st_d = IDLE;
      end
    endcase
  end
  // Receive FSM: qualify the start bit at half a bit, then sample each bit centre
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = (rx_cnt_q == BIT_END) ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (rx_st_q)
      IDLE: if (!rx_s2_q) begin
        rx_cnt_d = '0;
        rx_st_d  = START;
      end
      START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_cnt_q == BIT_END) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        rx_st_d  = (rx_bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (rx_cnt_q == BIT_END) begin
        push     = rx_s2_q;
        ferr_set = ~rx_s2_q;
        rx_st_d  = IDLE;
      end
    endcase
  end
  // Sticky error flags; a set in the same cycle as err_clr wins
  always_comb begin
    ferr_d = ferr_set | (ferr_q & ~err_clr);
    rxo_d  = rxo_set | (rxo_q & ~err_clr);
    txo_d  = (wr_edge & ~tbre_q) | (txo_q & ~err_clr);
  end
`ifdef UART_RX_FIFO_EN
  localparam int PW  = $clog2(RX_FIFO_DEPTH);
  localparam int CNW = PW + 1;
  logic [7:0]     mem_q [RX_FIFO_DEPTH];
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic           wr_ok;
  assign bus_dout = mem_q[rp_q];
  // FIFO bookkeeping; a push into a full FIFO is accepted only when a pop frees a slot that cycle
  always_comb begin
    wr_ok   = push & ((cnt_q != CNW'(RX_FIFO_DEPTH)) | pop);
    rxo_set = push & ~wr_ok;
    wp_d    = wr_ok ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q + CNW'(wr_ok) - CNW'(pop);
    dr_d    = cnt_d != '0;
  end
  // FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) mem_q[wp_q] <= rx_sh_q;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] rbr_q, rbr_d;
  assign bus_dout = rbr_q;
  // Single receive buffer; a byte arriving while one is unread is dropped unless a pop frees it that cycle
  always_comb begin
    rbr_d   = (push && (!dr_q || pop)) ? rx_sh_q : rbr_q;
    dr_d    = push | (dr_q & ~pop);
    rxo_set = push & dr_q & ~pop;
  end
  // Receive buffer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rbr_q <= '0;
    else rbr_q <= rbr_d;
  end
`endif
endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: table-driven and scoreboard checks of uart_responder with CLK_DIV=4
module tb_uart_responder;
  logic       clk = 1'b0;
  logic       rst, wrn, rdn, rxd, err_clr;
  logic [7:0] bus_din, bus_dout;
  logic       bus_oe, data_ready, tbre, tsre, txd, frame_err, rx_overrun, tx_overrun;
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_dr;
    logic       exp_fe;
  } rx_vec_t;
  rx_vec_t rx_tab [5];
  logic [7:0] tx_tab [3];
  uart_responder #(.CLK_DIV(4), .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_oe(bus_oe), .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
    .err_clr(err_clr), .frame_err(frame_err), .rx_overrun(rx_overrun), .tx_overrun(tx_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // serial line monitor: decodes each txd frame mid-bit and compares it with the transmit scoreboard
  int m_cnt = 0, m_frames = 0, m_start = 0, m_prev = 0;
  logic m_busy = 1'b0;
  logic [9:0] m_sh = '0;
  always @(posedge clk) begin
    #1;
    if (rst) m_busy = 1'b0;
    else if (!m_busy) begin
      if (txd == 1'b0) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_prev  = m_start;
        m_start = cyc;
      end
    end else begin
      m_cnt++;
      if (m_cnt % 4 == 2) m_sh[m_cnt/4] = txd;
      if (m_cnt == 38) begin
        m_busy = 1'b0;
        m_frames++;
        check("tx_start_bit", m_sh[0], 0);
        check("tx_stop_bit", m_sh[9], 1);
        check("tx_frame_expected", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) check("tx_data", m_sh[8:1], tx_q.pop_front());
      end
    end
  end
  task automatic wr_byte(input logic [7:0] b);
    bus_din = b;
    wrn = 1'b0;
    tick;
    wrn = 1'b1;
    tick;
  endtask
  task automatic tx_drain(input string name);
    for (int i = 0; i < 400 && (tx_q.size() != 0 || !tsre); i++) tick;
    check(name, tx_q.size(), 0);
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (4) tick;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) tick;
    end
    rxd = stop;
    repeat (4) tick;
    rxd = 1'b1;
    repeat (2) tick;
  endtask
  task automatic rd_check(input string name);
    logic [7:0] want;
    want = 'x;
    if (rx_q.size() != 0) want = rx_q.pop_front();
    rdn = 1'b0;
    tick;
    check({name, "_oe"}, bus_oe, 1);
    check({name, "_dout"}, bus_dout, want);
    rdn = 1'b1;
    tick;
  endtask
  task automatic clr_err;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] fr;
    int f0;
    rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    rx_tab[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
    rx_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    rx_tab[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    rx_tab[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
    tx_tab = '{8'h00, 8'hFF, 8'h96};
    rst = 1'b1; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1; err_clr = 1'b0; bus_din = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_txd", txd, 1);
    check("rst_tbre", tbre, 1);
    check("rst_tsre", tsre, 1);
    check("rst_dr", data_ready, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_dout", bus_dout, 0);
    check("rst_errs", {frame_err, rx_overrun, tx_overrun}, 0);
    // single frame 0xA5 checked bit by bit
    tx_q.push_back(8'hA5);
    wr_byte(8'hA5);
    check("t1_tbre_low", tbre, 0);
    tick;
    check("t1_tbre_reload", tbre, 1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      check($sformatf("t1_txd_c%0d", k), txd, fr[k/4]);
      if (k == 39) check("t1_tsre_busy", tsre, 0);
      tick;
    end
    check("t1_tsre_done", tsre, 1);
    tx_drain("t1_drain");
    // back-to-back writes, then a write into a full holding register
    f0 = m_frames;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    wr_byte(8'h01);
    wr_byte(8'h02);
    check("t2_txo_clear", tx_overrun, 0);
    wr_byte(8'h03);
    check("t2_txo_set", tx_overrun, 1);
    tx_drain("t2_drain");
    repeat (60) tick;
    check("t2_frames", m_frames - f0, 2);
    check("t2_gap", m_start - m_prev, 41);
    clr_err;
    check("t2_txo_clr", tx_overrun, 0);
    foreach (tx_tab[i]) begin
      tx_q.push_back(tx_tab[i]);
      wr_byte(tx_tab[i]);
      tx_drain($sformatf("txtab%0d_drain", i));
      check($sformatf("txtab%0d_tbre", i), tbre, 1);
    end
    // receive table: each frame then a read or an error clear
    for (int i = 0; i < 5; i++) begin
      if (rx_tab[i].stop) rx_q.push_back(rx_tab[i].data);
      rx_frame(rx_tab[i].data, rx_tab[i].stop);
      check($sformatf("rx%0d_dr", i), data_ready, rx_tab[i].exp_dr);
      check($sformatf("rx%0d_fe", i), frame_err, rx_tab[i].exp_fe);
      check($sformatf("rx%0d_oe_idle", i), bus_oe, 0);
      if (rx_tab[i].exp_dr) begin
        rd_check($sformatf("rx%0d_rd", i));
        check($sformatf("rx%0d_dr_clr", i), data_ready, 0);
      end
      if (rx_tab[i].exp_fe) begin
        clr_err;
        check($sformatf("rx%0d_fe_clr", i), frame_err, 0);
      end
    end
    // one-cycle glitch must not start a frame
    rxd = 1'b0;
    tick;
    rxd = 1'b1;
    repeat (20) tick;
    check("glitch_dr", data_ready, 0);
    check("glitch_fe", frame_err, 0);
    // read while empty
    rdn = 1'b0;
    tick;
    rdn = 1'b1;
    tick;
    check("empty_rd_dr", data_ready, 0);
`ifndef UART_RX_FIFO_EN
    check("empty_rd_dout", bus_dout, 8'hFF);
`endif
    // two frames with no read in between
    rx_q.push_back(8'h11);
    rx_frame(8'h11, 1'b1);
`ifdef UART_RX_FIFO_EN
    rx_q.push_back(8'h22);
    rx_frame(8'h22, 1'b1);
    check("t5_rxo", rx_overrun, 0);
    rd_check("t5_rd0");
    check("t5_dr_mid", data_ready, 1);
    rd_check("t5_rd1");
    check("t5_dr_end", data_ready, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_q.push_back(8'hA0 + 8'(i));
      rx_frame(8'hA0 + 8'(i), 1'b1);
    end
    check("t5_full_rxo", rx_overrun, 1);
    for (int i = 0; i < 4; i++) rd_check($sformatf("t5_full_rd%0d", i));
    check("t5_full_dr", data_ready, 0);
`else
    rx_frame(8'h22, 1'b1);
    check("t5_dr", data_ready, 1);
    check("t5_rxo", rx_overrun, 1);
    rd_check("t5_rd");
    check("t5_dr_end", data_ready, 0);
`endif
    clr_err;
    check("t5_rxo_clr", rx_overrun, 0);
    // reset in the middle of a frame, with the holding register also full
    wr_byte(8'h5A);
    wr_byte(8'h77);
    repeat (4) tick;
    check("t6_pre_txd", txd, 0);
    check("t6_pre_tbre", tbre, 0);
    check("t6_pre_tsre", tsre, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_txd", txd, 1);
    check("t6_tbre", tbre, 1);
    check("t6_tsre", tsre, 1);
    tx_q.delete();
    repeat (2) tick;
    rst = 1'b0;
    tick;
    tx_q.push_back(8'hC3);
    wr_byte(8'hC3);
    tx_drain("t6_drain");
    repeat (60) tick;
    check("t6_txo", tx_overrun, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
